// File: rtl/hack_memory_pkg.sv
// hack_memory_pkg: Hack data-memory map, region decode and screen FIFO entry type.
package hack_memory_pkg;

    localparam logic [14:0] RAM_BASE    = 15'h0000;
    localparam logic [14:0] SCREEN_BASE = 15'h4000;
    localparam logic [14:0] KBD_ADDR    = 15'h6000;
    localparam int          RAM_SIZE    = 16384;
    localparam int          SCREEN_SIZE = 8192;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_SCREEN,
        REGION_KBD,
        REGION_NONE
    } region_t;

    typedef struct packed {
        logic [12:0] addr;
        logic [15:0] data;
    } screenEntry_t;

    function automatic region_t decodeAddr(input logic [14:0] addr);
        return addr < SCREEN_BASE ? REGION_RAM :
               addr < KBD_ADDR    ? REGION_SCREEN :
               addr == KBD_ADDR   ? REGION_KBD : REGION_NONE;
    endfunction

endpackage

// File: rtl/screen_fifo.sv
// screen_fifo: show-ahead FIFO of screen writes; a push into a full FIFO is taken only alongside a pop.
module screen_fifo
    import hack_memory_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  screenEntry_t               pushEntry,
    input  logic                       pop,
    output screenEntry_t               head,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    screenEntry_t   mem [DEPTH];
    logic [AW-1:0]  wrPtr;
    logic [AW-1:0]  rdPtr;
    logic           doPush;

    assign full   = count == (AW+1)'(DEPTH);
    assign doPush = push && (!full || pop);
    assign head   = mem[rdPtr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (pop) rdPtr <= rdPtr + AW'(1);
            count <= count + (AW+1)'(doPush) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushEntry;
    end

endmodule

// File: rtl/hack_memory.sv
// hack_memory: Hack CPU data memory with RAM, screen shadow feeding a display FIFO, and keyboard register.
module hack_memory
    import hack_memory_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int RAM_WORDS    = RAM_SIZE,
    parameter int SCREEN_WORDS = SCREEN_SIZE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [14:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] inM,
    input  logic        kbd_valid,
    input  logic [15:0] kbd_code,
    input  logic        kbd_release,
    output logic        disp_valid,
    input  logic        disp_ready,
    output logic [12:0] disp_addr,
    output logic [15:0] disp_data,
    output logic        disp_overflow
);

    localparam int RAW = $clog2(RAM_WORDS);
    localparam int SAW = $clog2(SCREEN_WORDS);

    logic [15:0]                   ram    [RAM_WORDS];
    logic [15:0]                   screen [SCREEN_WORDS];
    logic [15:0]                   kbd;
    region_t                       region;
    logic [RAW-1:0]                ramIdx;
    logic [SAW-1:0]                screenIdx;
    logic [12:0]                   screenOff;
    logic                          screenWrite;
    logic                          pop;
    logic                          fifoFull;
    logic [$clog2(FIFO_DEPTH):0]   fifoCount;
    screenEntry_t                  head;

    assign region      = decodeAddr(addressM);
    assign ramIdx      = RAW'(addressM - RAM_BASE);
    assign screenOff   = 13'(addressM - SCREEN_BASE);
    assign screenIdx   = SAW'(addressM - SCREEN_BASE);
    assign screenWrite = writeM && region == REGION_SCREEN;
    assign pop         = disp_valid && disp_ready;
    assign disp_valid  = fifoCount != 0;
    assign disp_addr   = head.addr;
    assign disp_data   = head.data;

    always_comb begin
        inM = region == REGION_RAM    ? ram[ramIdx] :
              region == REGION_SCREEN ? screen[screenIdx] :
              region == REGION_KBD    ? kbd : '0;
    end

    // RAM and shadow keep their contents across reset.
    always_ff @(posedge clk) begin
        if (writeM && region == REGION_RAM) ram[ramIdx] <= outM;
        if (screenWrite) screen[screenIdx] <= outM;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kbd           <= '0;
            disp_overflow <= 1'b0;
        end else begin
            if (kbd_valid) kbd <= kbd_code;
            else if (kbd_release) kbd <= '0;
            if (screenWrite && fifoFull && !pop) disp_overflow <= 1'b1;
        end
    end

    screen_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (screenWrite),
        .pushEntry('{addr: screenOff, data: outM}),
        .pop      (pop),
        .head     (head),
        .full     (fifoFull),
        .count    (fifoCount)
    );

endmodule
